// File: rtl/sm3_compress.sv
// SM3 compression: one round per clock over a captured block, digest = rounds ^ V.
// Latency: digest/out_valid registered 64 edges after the accept edge.
// Backpressure: digest held in DONE until out_ready; in_ready only in IDLE, no queueing.
module sm3_compress (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [255:0]  iv,
    input  logic [2175:0] msg,
    input  logic [2047:0] msg0,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [255:0]  digest,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Field order matches the iv/digest packing (A in the top word).
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } wv_t;

    state_t         state;
    state_t         state_nxt;
    logic [5:0]     j;
    wv_t            wv;
    wv_t            wv_nxt;
    logic [255:0]   v_reg;
    logic [2047:0]  w_reg;
    logic [2047:0]  wp_reg;

    logic [31:0]    tj;
    logic [31:0]    a12;
    logic [31:0]    ss1;
    logic [31:0]    ss2;
    logic [31:0]    ff;
    logic [31:0]    gg;
    logic [31:0]    tt1;
    logic [31:0]    tt2;
    logic [31:0]    wj;
    logic [31:0]    wpj;

    // W64..W67 only feed W' upstream; the rounds never read them.
    logic           unused_w;
    assign unused_w = ^msg[2175:2048];

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] dbl;
        dbl = {x, x} << n;
        return dbl[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = ROUND;
            ROUND:   if (j == 6'd63)    state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == ROUND);
    end

    always_comb begin
        tj   = (j < 6'd16) ? 32'h79cc4519 : 32'h7a879d8a;
        a12  = rotl(wv.a, 5'd12);
        ss1  = rotl(a12 + wv.e + rotl(tj, j[4:0]), 5'd7);
        ss2  = ss1 ^ a12;
        ff   = (j < 6'd16) ? (wv.a ^ wv.b ^ wv.c)
                           : ((wv.a & wv.b) | (wv.a & wv.c) | (wv.b & wv.c));
        gg   = (j < 6'd16) ? (wv.e ^ wv.f ^ wv.g)
                           : ((wv.e & wv.f) | (~wv.e & wv.g));
        wj   = w_reg[{j, 5'd0} +: 32];
        wpj  = wp_reg[{j, 5'd0} +: 32];
        tt1  = ff + wv.d + ss2 + wpj;
        tt2  = gg + wv.h + ss1 + wj;

        wv_nxt.a = tt1;
        wv_nxt.b = wv.a;
        wv_nxt.c = rotl(wv.b, 5'd9);
        wv_nxt.d = wv.c;
        wv_nxt.e = p0(tt2);
        wv_nxt.f = wv.e;
        wv_nxt.g = rotl(wv.f, 5'd19);
        wv_nxt.h = wv.g;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wv        <= '0;
            v_reg     <= '0;
            w_reg     <= '0;
            wp_reg    <= '0;
            j         <= '0;
            digest    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wv     <= wv_t'(iv);
                        v_reg  <= iv;
                        w_reg  <= msg[2047:0];
                        wp_reg <= msg0;
                        j      <= '0;
                    end
                end
                ROUND: begin
                    wv <= wv_nxt;
                    // j parks at 63 until the next accept reloads it.
                    if (j == 6'd63) begin
                        digest    <= wv_nxt ^ v_reg;
                        out_valid <= 1'b1;
                    end else begin
                        j <= j + 6'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
